// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared FSM state type and power-datapath width helpers
package fft_pkg;

   typedef enum logic [1:0] {
      COLLECT = 2'd0,
      FLUSH   = 2'd1,
      STREAM  = 2'd2
   } fft_state_e;

   localparam int Q_IN_DEFAULT   = 15;
   localparam int Q_OUT_DEFAULT  = 15;
   localparam int ADDR_W_DEFAULT = 4;
   localparam int SHIFT_DEFAULT  = 15;

   // re^2 + im^2 of a (q_in+1)-bit signed sample; the worst case (-2^q_in)^2 * 2
   // is exactly 2^(2*q_in+1), which fits without wrapping.
   function automatic int sum_width(input int q_in);
      return 2 * (q_in + 1);
   endfunction

   // Width used for the shifted sum so the saturation test and the output
   // slice stay in range for any Q_IN/Q_OUT combination.
   function automatic int sat_width(input int q_in, input int q_out);
      int sw;
      sw = sum_width(q_in);
      return (sw > q_out + 1) ? sw : q_out + 1;
   endfunction

endpackage

// File: rtl/fft_power_sq.sv
// rtl/fft_power_sq.sv - two-stage |x|^2 >> SHIFT with saturation for one complex bin
module fft_power_sq
   import fft_pkg::*;
#(
   parameter int Q_IN  = Q_IN_DEFAULT,
   parameter int Q_OUT = Q_OUT_DEFAULT,
   parameter int SHIFT = SHIFT_DEFAULT
) (
   input  logic           clk_i,
   input  logic [Q_IN:0]  re_i,
   input  logic [Q_IN:0]  im_i,
   output logic [Q_OUT:0] power_o
);

   localparam int SUM_W = sum_width(Q_IN);
   localparam int EXT_W = sat_width(Q_IN, Q_OUT);

   logic signed [SUM_W-1:0] re_ext, im_ext;
   logic [SUM_W-1:0] re_sq_d, im_sq_d, re_sq_q, im_sq_q, sum;
   logic [EXT_W-1:0] shifted;
   logic             sat;
   logic [Q_OUT:0]   power_d, power_q;

   // Stage-1 squares from sign-extended samples, stage-2 shift and saturation.
   always_comb begin
      re_ext  = SUM_W'($signed(re_i));
      im_ext  = SUM_W'($signed(im_i));
      re_sq_d = re_ext * re_ext;
      im_sq_d = im_ext * im_ext;
      sum     = re_sq_q + im_sq_q;
      shifted = EXT_W'(sum) >> SHIFT;
      sat     = |(shifted >> (Q_OUT + 1));
      power_d = sat ? '1 : shifted[Q_OUT:0];
   end

   // Pure datapath registers; validity is tracked by the parent.
   always_ff @(posedge clk_i) begin
      re_sq_q <= re_sq_d;
      im_sq_q <= im_sq_d;
      power_q <= power_d;
   end

   assign power_o = power_q;

endmodule

// File: rtl/fft_mag_spectrum.sv
// rtl/fft_mag_spectrum.sv - FFT bin power spectrum with frame buffer, streaming output and optional peak search (FFT_MAG_PEAK_EN)
module fft_mag_spectrum
   import fft_pkg::*;
#(
   parameter int Q_IN   = Q_IN_DEFAULT,
   parameter int Q_OUT  = Q_OUT_DEFAULT,
   parameter int ADDR_W = ADDR_W_DEFAULT,
   parameter int SHIFT  = SHIFT_DEFAULT
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              valid_in,
   input  logic [ADDR_W-1:0] addr_in,
   input  logic [Q_IN:0]     data_real_0,
   input  logic [Q_IN:0]     data_imag_0,
   input  logic [Q_IN:0]     data_real_1,
   input  logic [Q_IN:0]     data_imag_1,
   input  logic              ready_out,
   output logic              valid_out,
   output logic [ADDR_W:0]   bin_addr_out,
   output logic [Q_OUT:0]    bin_power_out,
   output logic              last_out,
   output logic [ADDR_W:0]   peak_bin,
   output logic              peak_valid,
   output logic              overflow
);

   localparam int N_PAIRS = 1 << ADDR_W;
   localparam int N_BINS  = 2 * N_PAIRS;
   localparam int BIN_W   = ADDR_W + 1;

   fft_state_e          state_q, state_d;
   logic                v1_q, v1_d, v2_q, v2_d;
   logic [ADDR_W-1:0]   a1_q, a2_q;
   logic [N_PAIRS-1:0]  bitmap_q, bitmap_d, pair_bit;
   logic [BIN_W-1:0]    idx_q, idx_d;
   logic                ovf_q, ovf_d;
   logic [Q_OUT:0]      pow0, pow1;
   logic [Q_OUT:0]      bin_buf [N_BINS];
   logic                streaming, hs, final_hs, accept, wr, drop_wr;

   fft_power_sq #(.Q_IN(Q_IN), .Q_OUT(Q_OUT), .SHIFT(SHIFT)) u_sq0 (
      .clk_i   (clk),
      .re_i    (data_real_0),
      .im_i    (data_imag_0),
      .power_o (pow0)
   );

   fft_power_sq #(.Q_IN(Q_IN), .Q_OUT(Q_OUT), .SHIFT(SHIFT)) u_sq1 (
      .clk_i   (clk),
      .re_i    (data_real_1),
      .im_i    (data_imag_1),
      .power_o (pow1)
   );

   // Frame FSM, fill bitmap, stream index, input admission and overflow.
   always_comb begin
      streaming = (state_q == STREAM);
      hs        = streaming && ready_out;
      final_hs  = hs && (idx_q == BIN_W'(N_BINS - 1));
      // A pair arriving with the last handshake already belongs to the next frame.
      accept    = valid_in && ((state_q == COLLECT) || final_hs);
      wr        = v2_q && (state_q == COLLECT);
      drop_wr   = v2_q && !wr;
      pair_bit  = N_PAIRS'(1) << a2_q;

      state_d   = state_q;
      bitmap_d  = bitmap_q;
      idx_d     = idx_q;
      v1_d      = accept;
      v2_d      = v1_q;
      ovf_d     = ovf_q | (valid_in && !accept) | drop_wr;

      case (state_q)
         COLLECT: begin
            if (wr) begin
               bitmap_d = bitmap_q | pair_bit;
               if (&bitmap_d) state_d = FLUSH;
            end
         end
         FLUSH: begin
            idx_d   = '0;
            state_d = STREAM;
         end
         STREAM: begin
            if (hs) idx_d = idx_q + 1'b1;
            if (final_hs) begin
               idx_d    = '0;
               bitmap_d = '0;
               state_d  = COLLECT;
            end
         end
         default: state_d = COLLECT;
      endcase
   end

   // Control state with synchronous reset.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q  <= COLLECT;
         bitmap_q <= '0;
         v1_q     <= 1'b0;
         v2_q     <= 1'b0;
         idx_q    <= '0;
         ovf_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         bitmap_q <= bitmap_d;
         v1_q     <= v1_d;
         v2_q     <= v2_d;
         idx_q    <= idx_d;
         ovf_q    <= ovf_d;
      end
   end

   // Pair address travels alongside the power pipeline; meaningful only with its valid.
   always_ff @(posedge clk) begin
      a1_q <= addr_in;
      a2_q <= a1_q;
   end

   // Bin buffer: both bins of a pair land together; a repeated pair overwrites.
   always_ff @(posedge clk) begin
      if (wr) begin
         bin_buf[{a2_q, 1'b0}] <= pow0;
         bin_buf[{a2_q, 1'b1}] <= pow1;
      end
   end

   assign valid_out     = streaming;
   assign bin_addr_out  = streaming ? idx_q : '0;
   assign bin_power_out = streaming ? bin_buf[idx_q] : '0;
   assign last_out      = streaming && (idx_q == BIN_W'(N_BINS - 1));
   assign overflow      = ovf_q;

`ifdef FFT_MAG_PEAK_EN
   logic [Q_OUT:0] pk_max_q, pk_max_d;
   logic [BIN_W-1:0] pk_idx_q, pk_idx_d, pk_bin_q, pk_bin_d;
   logic pk_valid_q, pk_valid_d, pk_upd;

   // Running maximum over handshaked bins, DC excluded, strict compare keeps the lowest index.
   always_comb begin
      pk_upd     = hs && (idx_q != '0) && (bin_power_out > pk_max_q);
      pk_max_d   = pk_max_q;
      pk_idx_d   = pk_idx_q;
      pk_bin_d   = pk_bin_q;
      pk_valid_d = final_hs;
      if (state_q == FLUSH) begin
         pk_max_d = '0;
         pk_idx_d = BIN_W'(1);
      end else if (pk_upd) begin
         pk_max_d = bin_power_out;
         pk_idx_d = idx_q;
      end
      if (final_hs) pk_bin_d = pk_upd ? idx_q : pk_idx_q;
   end

   // Peak tracker registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         pk_max_q   <= '0;
         pk_idx_q   <= '0;
         pk_bin_q   <= '0;
         pk_valid_q <= 1'b0;
      end else begin
         pk_max_q   <= pk_max_d;
         pk_idx_q   <= pk_idx_d;
         pk_bin_q   <= pk_bin_d;
         pk_valid_q <= pk_valid_d;
      end
   end

   assign peak_bin   = pk_bin_q;
   assign peak_valid = pk_valid_q;
`else
   assign peak_bin   = '0;
   assign peak_valid = 1'b0;
`endif

endmodule

// File: doc/fft_mag_spectrum.md
FFT_MAG_SPECTRUM -- requirements
Module: fft_mag_spectrum

Interface
REQ-001 Parameter Q_IN, default 15; FFT sample MSB index, so samples are Q_IN+1 bits signed.
REQ-002 Parameter Q_OUT, default 15; power output MSB index, so power is Q_OUT+1 bits unsigned.
REQ-003 Parameter ADDR_W, default 4; pair-address width, with N_PAIRS = 2^ADDR_W and N_BINS = 2*N_PAIRS.
REQ-004 Parameter SHIFT, default 15; right shift applied to the raw power before saturation.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 reset  in  1  synchronous, active-high.
REQ-007 valid_in  in  1  input pair present this cycle.
REQ-008 addr_in  in  ADDR_W  pair index p; carries bins 2p and 2p+1.
REQ-009 data_real_0, data_imag_0, data_real_1, data_imag_1  in  Q_IN+1 each  signed bins 2p and 2p+1.
REQ-010 ready_out  in  1  downstream accepts an output bin.
REQ-011 valid_out  out  1  output bin present.
REQ-012 bin_addr_out  out  ADDR_W+1  bin index 0..N_BINS-1.
REQ-013 bin_power_out  out  Q_OUT+1  unsigned bin power.
REQ-014 last_out  out  1  high with the final bin of a frame.
REQ-015 peak_bin  out  ADDR_W+1  index of the maximum-power bin.
REQ-016 peak_valid  out  1  one-cycle pulse; peak_bin is valid.
REQ-017 overflow  out  1  sticky flag; an input was dropped.

Function
REQ-018 Power datapath: stage 1 registers re^2 and im^2 per bin; stage 2 registers (re^2+im^2)>>>SHIFT, saturated to 2^(Q_OUT+1)-1; latency 2 cycles, full rate, both bins in parallel.
REQ-019 Intermediate sum width SHALL be 2*(Q_IN+1) bits; (-2^Q_IN)^2 summed twice SHALL NOT wrap.
REQ-020 Stage-2 results SHALL be written to a bin buffer at 2p and 2p+1, and bit p of a fill bitmap SHALL be set.
REQ-021 A repeated addr_in within a frame SHALL overwrite the stored pair; the bitmap is unchanged.
REQ-022 FSM states: COLLECT (reset state), FLUSH, STREAM.
REQ-023 COLLECT->FLUSH when the stage-2 write completes the bitmap; FLUSH lasts exactly 1 cycle; FLUSH->STREAM unconditionally.
REQ-024 STREAM: bins are presented in order 0..N_BINS-1; an index advances only on valid_out && ready_out; outputs hold stable while ready_out is low.
REQ-025 last_out SHALL be high only with bin N_BINS-1; that handshake clears the bitmap and returns the FSM to COLLECT.
REQ-026 valid_in during FLUSH or STREAM, or in-flight pipeline data completing in those states, SHALL be discarded with no buffer write, and overflow SHALL be set.
REQ-027 valid_in on the same cycle as the final STREAM handshake SHALL be accepted into the new frame.
REQ-028 Peak search runs during STREAM on handshaked bins.
- The comparison is strictly greater, so the lowest index wins ties.
- Bin 0 (DC) is excluded.
- If all powers are 0, peak_bin = 1.
REQ-029 peak_valid SHALL pulse on the cycle after the last_out handshake.

Reset
REQ-030 Reset SHALL put the FSM in COLLECT and clear the bitmap, pipeline valids and peak tracker.
REQ-031 Reset SHALL drive valid_out, last_out, peak_valid and overflow to 0, and bin_addr_out, bin_power_out and peak_bin to 0.
REQ-032 Buffer contents need not be reset.
REQ-033 Reset mid-frame or mid-STREAM SHALL abandon the frame; no partial output follows.

Configuration
REQ-034 Macro FFT_MAG_PEAK_EN: when defined, peak tracking per REQ-028/REQ-029 is compiled in.
REQ-035 When FFT_MAG_PEAK_EN is undefined, peak_bin and peak_valid are tied to 0, no comparator logic is present, and all other behaviour is unchanged.

Structure
REQ-036 Shared package fft_pkg SHALL hold the FSM state enum (COLLECT, FLUSH, STREAM) and the saturating-shift width constants.
REQ-037 One sub-module, fft_power_sq, SHALL implement the 2-stage power datapath for one complex bin and be instantiated twice.

Verification
REQ-038 Pair p=0..15 each with re0=re1=1000, im=0, ready_out=1 -> 32 bins with power 30 ((10^6)>>15), last_out on bin 31, peak_bin=1.
REQ-039 re=-32768, im=-32768 on pair 5 -> bins 10/11 power 65535 (saturated); peak_bin=10.
REQ-040 ready_out toggled 1/0 during STREAM -> no bin skipped or duplicated; values stable while ready_out=0; 32 handshakes total.
REQ-041 valid_in asserted during STREAM -> overflow=1 and the next frame is unaffected; valid_in on the final-handshake cycle -> accepted into the new frame.
REQ-042 Pair 3 sent twice with powers 100 then 200 -> bin 6 outputs 200; the frame completes after 16 unique pairs.
REQ-043 Reset asserted mid-STREAM at bin 12 -> valid_out=0 next cycle; the next full frame streams from bin 0.
